// File: rtl/lut_ram_loader_pkg.sv
// rtl/lut_ram_loader_pkg.sv - shared types and constants for the lut_ram byte-stream loader
package lut_ram_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/lut_ram_loader.sv
// rtl/lut_ram_loader.sv - assembles a byte stream into little-endian words and writes them to lut_ram
// Writes go to consecutive addresses from a latched base, wrapping at the top of the address space.
module lut_ram_loader
  import lut_ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [BYTE_W-1:0]     byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / BYTE_W;
  localparam int CNT_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  loader_state_t         state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic [CNT_W-1:0]      byte_cnt_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] word_d;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  done_q;

  // Current word with the incoming byte dropped into its little-endian lane.
  always_comb begin
    word_d = word_q;
    word_d[int'(byte_cnt_q) * BYTE_W +: BYTE_W] = byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (num_words != '0) begin
              base_q     <= base_addr;
              num_q      <= num_words;
              word_cnt_q <= '0;
              byte_cnt_q <= '0;
              word_q     <= '0;
              state_q    <= COLLECT;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        COLLECT: begin
          if (byte_valid) begin
            word_q <= word_d;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              wr_en_q    <= 1'b1;
              wr_addr_q  <= base_q + word_cnt_q[ADDR_WIDTH-1:0];
              wr_data_q  <= word_d;
              state_q    <= WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          word_cnt_q <= word_cnt_q + 1'b1;
          if (word_cnt_q == num_q - 1'b1) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= COLLECT;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready depends on state alone so the upstream valid can never loop back into it.
  assign byte_ready = (state_q == COLLECT);
  assign busy       = (state_q != IDLE);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lut_ram_loader.sv
// tb/tb_lut_ram_loader.sv - scoreboard bench for lut_ram_loader
module tb_lut_ram_loader;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NW = AW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stream_q[$];
  int n_vec = 0;
  int n_err = 0;
  int writes_seen = 0;
  int done_cnt = 0;
  int bytes_sent = 0;

  lut_ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Write monitor: pops the scoreboard on every write and flags writes that split a word.
  always @(negedge clk) begin
    wr_t e;
    if (done === 1'b1) done_cnt++;
    if (wr_en === 1'b1) begin
      writes_seen++;
      n_vec++;
      if (bytes_sent == 0 || (bytes_sent % 4) != 0) begin
        n_err++;
        $display("FAIL mid_word_write: bytes_accepted=%0d, required a nonzero multiple of 4", bytes_sent);
      end
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_err++;
          $display("FAIL write: got %h@%h, required %h@%h", wr_data, wr_addr, e.data, e.addr);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n, input bit fresh);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    if (fresh) begin
      bytes_sent = 0;
      writes_seen = 0;
      done_cnt = 0;
    end
    @(negedge clk);
    start = 1'b0;
    base_addr = AW'($urandom);
    num_words = NW'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in = 8'hEE;
    end
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited >= 50) begin
      n_err++;
      $display("FAIL byte_accept_timeout: byte_ready=%b, required 1 within 50 cycles", byte_ready);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      bytes_sent++;
    end
  endtask

  task automatic drive_stream(input int gap);
    while (stream_q.size() != 0) send_byte(stream_q.pop_front(), gap);
  endtask

  task automatic random_words(input logic [AW-1:0] b, input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      exp_q.push_back(wr_t'{addr: AW'(int'(b) + i), data: w});
      for (int k = 0; k < DW / 8; k++) stream_q.push_back(w[8*k +: 8]);
    end
  endtask

  task automatic finish_load(input int n_writes);
    int waited = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    while (done !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_vec++;
    if (waited >= 100) begin
      n_err++;
      $display("FAIL done_timeout: done=%b, required 1 within 100 cycles", done);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_done: got %b, required 1", busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_drop: busy=%b done=%b, required 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL done_pulses: got %0d, required 1", done_cnt);
    end
    n_vec++;
    if (writes_seen !== n_writes || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL write_count: got %0d writes with %0d pending, required %0d and 0", writes_seen, exp_q.size(), n_writes);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_vec++;
    if (byte_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s: ready=%b wr_en=%b addr=%h data=%h busy=%b done=%b, required all zero",
               tag, byte_ready, wr_en, wr_addr, wr_data, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_values");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset_values");
  endtask

  task automatic test_basic();
    exp_q.push_back(wr_t'{addr: 8'h10, data: 32'h44332211});
    exp_q.push_back(wr_t'{addr: 8'h11, data: 32'h88776655});
    stream_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_start(8'h10, 9'd2, 1'b1);
    drive_stream(0);
    finish_load(2);
  endtask

  task automatic test_bubbles();
    exp_q.push_back(wr_t'{addr: 8'h10, data: 32'h44332211});
    exp_q.push_back(wr_t'{addr: 8'h11, data: 32'h88776655});
    stream_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_start(8'h10, 9'd2, 1'b1);
    drive_stream(3);
    finish_load(2);
  endtask

  task automatic test_wrap();
    random_words(8'hFE, 3);
    do_start(8'hFE, 9'd3, 1'b1);
    drive_stream(1);
    finish_load(3);
  endtask

  task automatic test_zero_length();
    do_start(8'h33, 9'd0, 1'b1);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_done: done=%b busy=%b ready=%b, required 1 1 0", done, busy, byte_ready);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_idle: done=%b busy=%b ready=%b, required 0 0 0", done, busy, byte_ready);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (writes_seen !== 0 || done_cnt !== 1) begin
      n_err++;
      $display("FAIL zero_len_count: writes=%0d done_pulses=%0d, required 0 1", writes_seen, done_cnt);
    end
  endtask

  task automatic test_reset_mid_word();
    stream_q = '{8'hAA, 8'hBB};
    do_start(8'h40, 9'd1, 1'b1);
    drive_stream(0);
    @(negedge clk);
    byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid_word_reset");
    n_vec++;
    if (writes_seen !== 0) begin
      n_err++;
      $display("FAIL mid_word_reset_write: got %0d writes, required 0", writes_seen);
    end
    exp_q.push_back(wr_t'{addr: 8'h40, data: 32'h04030201});
    stream_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    do_start(8'h40, 9'd1, 1'b1);
    drive_stream(0);
    finish_load(1);
  endtask

  task automatic test_start_while_busy();
    random_words(8'h80, 2);
    do_start(8'h80, 9'd2, 1'b1);
    for (int i = 0; i < 2; i++) send_byte(stream_q.pop_front(), 0);
    @(negedge clk);
    byte_valid = 1'b0;
    do_start(8'h20, 9'd5, 1'b0);
    n_vec++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_while_busy_state: busy=%b ready=%b, required 1 1", busy, byte_ready);
    end
    drive_stream(0);
    finish_load(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_wrap();
    test_zero_length();
    test_reset_mid_word();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
